vibrato_controller: RTL

VIBRATO_CONTROLLER -- requirements
Module: vibrato_controller

---
 rtl/vibrato_controller.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vibrato_controller.sv
// Vibrato LFO controller: triangle LFO scaled by depth, slew-limited delay tap, enable ramps.
// Latency: read_shift/shift_valid update on the clk edge after a sample_tick cycle (1 clk).
// Backpressure: single pending config slot; cfg_ready low while full, freed only by sample_tick.
module vibrato_controller #(
  parameter int SHIFT_WIDTH = 7,
  parameter int PHASE_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_tick,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_rate,
  input  logic [3:0]             cfg_depth,
  input  logic                   cfg_enable,
  output logic [SHIFT_WIDTH-1:0] read_shift,
  output logic                   shift_valid,
  output logic                   busy,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic                   shift_vld_q, shift_vld_d;

  // Pending config slot, filled by the handshake and drained only by a tick
  logic                   pend_vld_q, pend_vld_d;
  logic [PHASE_WIDTH-1:0] pend_rate_q, pend_rate_d;
  logic [3:0]             pend_depth_q, pend_depth_d;
  logic                   pend_en_q, pend_en_d;

  // Active configuration used by the LFO
  logic [PHASE_WIDTH-1:0] rate_q, rate_d;
  logic [3:0]             depth_q, depth_d;
  logic                   en_q, en_d;

  logic                   accept;
  logic                   apply_en;
  logic                   apply_dis;
  logic [6:0]             tri_val;
  logic [10:0]            prod;
  logic [SHIFT_WIDTH-1:0] target;

  assign accept    = cfg_valid & ~pend_vld_q;
  // Only an actual change of enable moves the state machine
  assign apply_en  = pend_vld_q & pend_en_q & ~en_q;
  assign apply_dis = pend_vld_q & ~pend_en_q & en_q;

  // Triangle from the pre-add phase: rising in the lower half, folded in the upper half
  assign tri_val = phase_q[PHASE_WIDTH-1] ? ~phase_q[PHASE_WIDTH-2 -: 7]
                                          :  phase_q[PHASE_WIDTH-2 -: 7];
  assign prod    = 11'(tri_val) * 11'(depth_q);
  assign target  = (state_q == ST_RAMP_DOWN) ? '0 : SHIFT_WIDTH'(prod[10:4]);

  // Next-state: step with pre-tick regs, then apply pending config, then transition
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    shift_d      = shift_q;
    shift_vld_d  = 1'b0;
    pend_vld_d   = pend_vld_q;
    pend_rate_d  = pend_rate_q;
    pend_depth_d = pend_depth_q;
    pend_en_d    = pend_en_q;
    rate_d       = rate_q;
    depth_d      = depth_q;
    en_d         = en_q;

    if (sample_tick) begin
      if (state_q != ST_IDLE) begin
        if (target > shift_q) begin
          shift_d = shift_q + SHIFT_WIDTH'(1);
        end else if (target < shift_q) begin
          shift_d = shift_q - SHIFT_WIDTH'(1);
        end
        phase_d = phase_q + rate_q;
      end

      if (pend_vld_q) begin
        rate_d     = pend_rate_q;
        depth_d    = pend_depth_q;
        en_d       = pend_en_q;
        pend_vld_d = 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (apply_en) state_d = ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (apply_dis)              state_d = ST_RAMP_DOWN;
          else if (shift_d == target) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (apply_dis) state_d = ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          // Re-enable wins over landing on zero
          if (apply_en) begin
            state_d = ST_RAMP_UP;
          end else if (shift_d == '0) begin
            state_d = ST_IDLE;
            phase_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Pulse covers the enabling tick and the final step down to zero
      shift_vld_d = (state_q != ST_IDLE) || (state_d != ST_IDLE);
    end

    // A config offered alongside a tick lands in the slot after that tick
    if (accept) begin
      pend_vld_d   = 1'b1;
      pend_rate_d  = cfg_rate;
      pend_depth_d = cfg_depth;
      pend_en_d    = cfg_enable;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      shift_q      <= '0;
      shift_vld_q  <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_rate_q  <= '0;
      pend_depth_q <= '0;
      pend_en_q    <= 1'b0;
      rate_q       <= '0;
      depth_q      <= '0;
      en_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      shift_q      <= shift_d;
      shift_vld_q  <= shift_vld_d;
      pend_vld_q   <= pend_vld_d;
      pend_rate_q  <= pend_rate_d;
      pend_depth_q <= pend_depth_d;
      pend_en_q    <= pend_en_d;
      rate_q       <= rate_d;
      depth_q      <= depth_d;
      en_q         <= en_d;
    end
  end

  assign cfg_ready   = ~pend_vld_q;
  assign read_shift  = shift_q;
  assign shift_valid = shift_vld_q;
  assign busy        = (state_q != ST_IDLE);
  assign state       = state_q;

endmodule
